rcpu_sequencer: RTL

Multi-cycle control sequencer for the R-type CPU datapath (instruction ROM, register file, 32-bit ALU, PC adder). It replaces free-running per-clock PC advance and hard-tied write enable with an explicit FETCH/DECODE/EXEC/WB state machine. The FSM generates IR load, PC increment, register-file write enable and ALU opcode, and supports run/step/halt control, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction memory output and the datapath control lines.

---
 rtl/rcpu_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rcpu_sequencer.sv
// rcpu_sequencer
//   Multi-cycle control sequencer for the R-type CPU datapath. Walks each
//   instruction through FETCH / DECODE / EXEC / WB and drives the datapath
//   control lines from the current state and the held decode registers.
//
// Parameters
//   FETCH_WAIT  extra FETCH cycles before the IR is loaded (0..15)
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk        rising-edge clock
//   areset     asynchronous active-low reset
//   run        continuous-execution enable
//   step       single-instruction request (taken only in IDLE with run=0)
//   halt_req   stop after the current instruction retires
//   inst       instruction word from instruction memory
//   ir_load    load the instruction register this cycle
//   pc_inc     PC += 4 at the end of this cycle
//   reg_write  register-file write enable
//   alu_op     00=AND 01=OR 10=ADD 11=SUB
//   busy       state is neither IDLE nor TRAP
//   illegal    sticky illegal-instruction flag
//   state      current state encoding (debug)
//   retired    count of instructions that reached WB (wraps)
//
// There is no valid/ready handshake on this block: inst is assumed stable
// and valid in the cycle ir_load is high (FETCH_WAIT models ROM latency).

module rcpu_sequencer #(
  parameter int FETCH_WAIT = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      inst,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] FW_CNT = 4'(FETCH_WAIT);

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       wait_q;
  logic             fetch_done;
  logic [11:0]      ir_q;        // {opcode[31:26], funct[5:0]}
  logic [1:0]       alu_q;
  logic             illegal_q;
  logic [CNT_W-1:0] ret_q;
  logic             dec_legal;
  logic [1:0]       dec_op;

  // Only the opcode and funct fields matter to the sequencer; the register
  // specifier bits belong to the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[25:6];

  assign fetch_done = (wait_q == FW_CNT);

  // Decode of the held instruction word.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = alu_q;
    if (ir_q[11:6] == 6'd0) begin
      case (ir_q[5:0])
        6'b100100: begin dec_legal = 1'b1; dec_op = 2'b00; end
        6'b100101: begin dec_legal = 1'b1; dec_op = 2'b01; end
        6'b100000: begin dec_legal = 1'b1; dec_op = 2'b10; end
        6'b100010: begin dec_legal = 1'b1; dec_op = 2'b11; end
        default:   begin dec_legal = 1'b0; dec_op = alu_q; end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run || step) state_d = S_FETCH;
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = S_WB;
      // halt_req is only looked at here, so it wins over run.
      S_WB:     state_d = (run && !halt_req) ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      ir_q      <= 12'd0;
      alu_q     <= 2'b00;
      illegal_q <= 1'b0;
      ret_q     <= '0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every FETCH entry because it is cleared in
      // every other state, including the final FETCH cycle.
      wait_q  <= (state_q == S_FETCH && !fetch_done) ? wait_q + 4'd1 : 4'd0;
      if (ir_load) ir_q <= {inst[31:26], inst[5:0]};
      // alu_op only changes at the DECODE edge, never while WB writes.
      if (state_q == S_DECODE && dec_legal) alu_q <= dec_op;
      if (state_q == S_DECODE && !dec_legal) illegal_q <= 1'b1;
      if (state_q == S_WB) ret_q <= ret_q + CNT_W'(1);
    end
  end

  // Outputs decode only registered state, so reset clears them at once.
  assign ir_load   = (state_q == S_FETCH) && fetch_done;
  assign reg_write = (state_q == S_WB);
  assign pc_inc    = (state_q == S_WB);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_WB);
  assign alu_op    = alu_q;
  assign illegal   = illegal_q;
  assign state     = state_q;
  assign retired   = ret_q;

endmodule
